// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: word width, DIV funct code and divider state encoding.
package cpu_defs;

   localparam int unsigned WORD_W = 32;

   // funct field of the DIV instruction, shared with control_unit
   localparam logic [5:0] DIV = 6'h1a;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_ZERO = 2'd3
   } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative signed restoring divider for the DIV instruction (MIPS semantics:
// quotient truncates toward zero, remainder takes the dividend's sign).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   DivCtrl         start request, accepted only in IDLE
//   A, B            dividend / divisor (two's complement)
//   HI, LO          remainder / quotient, written only when a division completes
//   DivZero         one-cycle pulse: divisor was zero, HI/LO untouched
//   DivStop         one-cycle pulse: HI/LO hold a new result
//   busy            high while an operation is in progress
module div_unit
   import cpu_defs::*;
#(
   parameter int unsigned WIDTH = WORD_W,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DivCtrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             DivZero,
   output logic             DivStop,
   output logic             busy
);

   div_state_t       state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             sign_quo_q, sign_quo_d;
   logic             sign_rem_q, sign_rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             zero_q, zero_d;
   logic             stop_q, stop_d;
   logic             busy_q, busy_d;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] quo_sh;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= DIV_IDLE;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         sign_quo_q <= 1'b0;
         sign_rem_q <= 1'b0;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         zero_q     <= 1'b0;
         stop_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         sign_quo_q <= sign_quo_d;
         sign_rem_q <= sign_rem_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         zero_q     <= zero_d;
         stop_q     <= stop_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      sign_quo_d = sign_quo_q;
      sign_rem_d = sign_rem_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      zero_d     = 1'b0;
      stop_d     = 1'b0;
      busy_d     = busy_q;

      // Next dividend bit shifts from the quotient register into the remainder
      rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      quo_sh = {quo_q[WIDTH-2:0], 1'b0};

      case (state_q)
         DIV_IDLE: begin
            if (DivCtrl) begin
               sign_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
               sign_rem_d = A[WIDTH-1];
               // Magnitudes; the most negative value maps onto itself as unsigned
               quo_d      = A[WIDTH-1] ? -A : A;
               dvs_d      = B[WIDTH-1] ? -B : B;
               rem_d      = '0;
               cnt_d      = '0;
               busy_d     = 1'b1;
               if (B == '0) begin
                  state_d = DIV_ZERO;
                  zero_d  = 1'b1;
               end else begin
                  state_d = DIV_RUN;
               end
            end
         end
         DIV_RUN: begin
            if (rem_sh >= {1'b0, dvs_q}) begin
               rem_d = rem_sh - {1'b0, dvs_q};
               quo_d = quo_sh | WIDTH'(1);
            end else begin
               rem_d = rem_sh;
               quo_d = quo_sh;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DIV_FIX;
            end
         end
         DIV_FIX: begin
            lo_d    = sign_quo_q ? -quo_q : quo_q;
            hi_d    = sign_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            stop_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DIV_IDLE;
         end
         DIV_ZERO: begin
            busy_d  = 1'b0;
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase
   end

   assign HI      = hi_q;
   assign LO      = lo_q;
   assign DivZero = zero_q;
   assign DivStop = stop_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands
// against a wide-integer reference model of signed division.
module tb_div_unit;

   localparam int unsigned W = 32;

   logic         clk;
   logic         reset;
   logic         DivCtrl;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] HI;
   logic [W-1:0] LO;
   logic         DivZero;
   logic         DivStop;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Architectural HI/LO as the model expects them
   logic [W-1:0] hi_m;
   logic [W-1:0] lo_m;

   div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk     (clk),
      .reset   (reset),
      .DivCtrl (DivCtrl),
      .A       (A),
      .B       (B),
      .HI      (HI),
      .LO      (LO),
      .DivZero (DivZero),
      .DivStop (DivStop),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: 64-bit signed arithmetic truncates toward zero, remainder follows dividend
   task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r);
      longint sa, sb, lq, lr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
   endtask

   // Drive a start at the current negedge; returns at the negedge after edge k
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      A       = a;
      B       = b;
      DivCtrl = 1'b1;
      @(posedge clk);
      @(negedge clk);
      DivCtrl = 1'b0;
      A       = $urandom;
      B       = $urandom;
   endtask

   // Full operation; ign > 0 injects a stray start sampled at edge k+ign
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int ign);
      logic [W-1:0] q, r;
      int  n;
      bit  done, zero_seen, busy_drop;
      start_op(a, b);
      check_eq("start_busy", 64'(busy), 64'd1);
      check_eq("stop_clear", 64'(DivStop), 64'd0);
      if (b == '0) begin
         check_eq("zero_pulse", 64'(DivZero), 64'd1);
         @(negedge clk);
         check_eq("zero_clear", 64'(DivZero), 64'd0);
         check_eq("zero_busy", 64'(busy), 64'd0);
         check_eq("zero_nostop", 64'(DivStop), 64'd0);
         check_eq("zero_hi", 64'(HI), 64'(hi_m));
         check_eq("zero_lo", 64'(LO), 64'(lo_m));
         return;
      end
      check_eq("nozero", 64'(DivZero), 64'd0);
      ref_div(a, b, q, r);
      n = 0; done = 0; zero_seen = 0; busy_drop = 0;
      while (n < 40 && !done) begin
         if (ign > 0 && n == ign - 1) begin
            DivCtrl = 1'b1;
            A       = 32'd9;
            B       = 32'd3;
         end else begin
            DivCtrl = 1'b0;
            A       = $urandom;
            B       = $urandom;
         end
         @(negedge clk);
         n++;
         if (DivZero) zero_seen = 1;
         if (DivStop) done = 1;
         else if (!busy) busy_drop = 1;
      end
      DivCtrl = 1'b0;
      hi_m = r;
      lo_m = q;
      check_eq("latency", 64'(n), 64'd33);
      check_eq("lo", 64'(LO), 64'(lo_m));
      check_eq("hi", 64'(HI), 64'(hi_m));
      check_eq("end_busy", 64'(busy), 64'd0);
      check_eq("run_nozero", 64'(zero_seen), 64'd0);
      check_eq("run_busy", 64'(busy_drop), 64'd0);
   endtask

   initial begin
      bit stop_seen;
      logic [W-1:0] ra, rb;
      clk     = 1'b0;
      reset   = 1'b1;
      DivCtrl = 1'b0;
      A       = '0;
      B       = '0;
      hi_m    = '0;
      lo_m    = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_hi", 64'(HI), 64'd0);
      check_eq("rst_lo", 64'(LO), 64'd0);
      check_eq("rst_flags", 64'({DivZero, DivStop, busy}), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      do_op(32'd100, 32'd7, 0);
      check_eq("d100_7_lo", 64'(LO), 64'd14);
      check_eq("d100_7_hi", 64'(HI), 64'd2);
      do_op(32'hFFFF_FFF9, 32'd2, 0);
      check_eq("dm7_2_lo", 64'(LO), 64'hFFFF_FFFD);
      check_eq("dm7_2_hi", 64'(HI), 64'hFFFF_FFFF);
      do_op(32'd7, 32'hFFFF_FFFE, 0);
      check_eq("d7_m2_lo", 64'(LO), 64'hFFFF_FFFD);
      check_eq("d7_m2_hi", 64'(HI), 64'd1);
      do_op(32'd100, 32'd7, 0);
      do_op(32'd5, 32'd0, 0);
      check_eq("d5_0_lo", 64'(LO), 64'd14);
      check_eq("d5_0_hi", 64'(HI), 64'd2);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
      check_eq("dmin_m1_lo", 64'(LO), 64'h8000_0000);
      check_eq("dmin_m1_hi", 64'(HI), 64'd0);
      do_op(32'd100, 32'd7, 5);
      check_eq("ign_lo", 64'(LO), 64'd14);
      check_eq("ign_hi", 64'(HI), 64'd2);

      // Reset in the middle of a division
      start_op(32'd100, 32'd7);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      hi_m  = '0;
      lo_m  = '0;
      check_eq("mrst_hi", 64'(HI), 64'd0);
      check_eq("mrst_lo", 64'(LO), 64'd0);
      check_eq("mrst_flags", 64'({DivZero, DivStop, busy}), 64'd0);
      stop_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (DivStop || busy) stop_seen = 1;
      end
      check_eq("mrst_quiet", 64'(stop_seen), 64'd0);
      do_op(32'd9, 32'd3, 0);
      check_eq("d9_3_lo", 64'(LO), 64'd3);
      check_eq("d9_3_hi", 64'(HI), 64'd0);

      // Random operands, back-to-back starts, with some boundary divisors mixed in
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'($urandom_range(1, 15));
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'h8000_0000;
            3: rb = '0;
            default: ;
         endcase
         do_op(ra, rb, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
